// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter fed by CPU stores through a small byte FIFO; stores to a full FIFO are dropped and flagged.
// Start latency one cycle after the accepting store; define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module uart_tx_mmio #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataIO,
   output logic        tx,
   output logic        busy,
   output logic        full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [AW:0]   LP_DEPTH     = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   LP_CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] LP_PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] LP_BAUD_ONE  = CW'(1);
   localparam logic [CW-1:0] LP_BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   state_t        r_state;
   logic [CW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_overflow;
`ifdef UART_TX_PARITY_EN
   logic          r_parity;
`endif

   logic       w_data_sel;
   logic       w_stat_sel;
   logic       w_push_req;
   logic       w_push;
   logic       w_pop;
   logic       w_fifo_vld;
   logic       w_bit_done;
   logic [7:0] w_head;
   logic       w_unused_wdata;

   assign w_data_sel     = (ALUResultM == BASE_ADDR);
   assign w_stat_sel     = (ALUResultM == BASE_ADDR + 32'd4);
   assign w_push_req     = MemWriteM & w_data_sel;
   assign w_push         = w_push_req & ~full;
   assign w_fifo_vld     = (r_count != '0);
   assign w_bit_done     = (r_baud == LP_BAUD_LAST);
   assign w_pop          = w_fifo_vld & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_done));
   assign w_head         = r_mem[r_rptr];
   assign w_unused_wdata = ^WriteDataM[31:8];

   assign full       = (r_count == LP_DEPTH);
   assign busy       = (r_state != S_IDLE) | w_fifo_vld;
   assign tx         = r_tx;
   assign ReadDataIO = w_stat_sel ? {29'b0, r_overflow, full, busy} : 32'd0;

   // Storage needs no reset: entries are only read while the count says they are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= WriteDataM[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + LP_PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + LP_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_push_req && full) begin
            r_overflow <= 1'b1;
         end else if (MemWriteM && w_stat_sel) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_baud <= w_bit_done ? '0 : r_baud + LP_BAUD_ONE;
         case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               if (w_fifo_vld) begin
                  r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                  r_parity <= ^w_head;
`endif
                  r_tx     <= 1'b0;
                  r_state  <= S_START;
               end
            end
            S_START: begin
               if (w_bit_done) begin
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_done) begin
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_done) begin
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
               if (w_bit_done) begin
                  if (w_fifo_vld) begin
                     r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                     r_parity <= ^w_head;
`endif
                     r_tx     <= 1'b0;
                     r_state  <= S_START;
                  end else begin
                     r_state  <= S_IDLE;
                  end
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
